// File: rtl/pong_ball_engine_pkg.sv
// Shared types, default geometry and small velocity helpers for the pong ball engine.
package pong_ball_engine_pkg;

    // FSM state encodings, also visible on the state output.
    typedef enum logic [1:0] {
        S_MOVE   = 2'd0,
        S_SCORED = 2'd1,
        S_SERVE  = 2'd2,
        S_HALT   = 2'd3
    } state_e;

    // Paddle motion encodings.
    localparam logic [1:0] DIR_DOWN = 2'b01;
    localparam logic [1:0] DIR_UP   = 2'b10;

    // Default playfield geometry.
    localparam int FIELD_W_DEF     = 1024;
    localparam int FIELD_H_DEF     = 600;
    localparam int BALL_SIZE_DEF   = 30;
    localparam int PAD_L_X_DEF     = 62;
    localparam int PAD_R_X_DEF     = 962;
    localparam int MAX_SPEED_DEF   = 4;
    localparam int SERVE_DELAY_DEF = 60;
    localparam int XW_DEF          = 11;
    localparam int YW_DEF          = 10;
    localparam int SW_DEF          = 8;

    // Signed velocity word: holds -MAX_SPEED..+MAX_SPEED plus one step of headroom.
    localparam int VW = 4;
    typedef logic signed [VW-1:0] vel_t;

    function automatic vel_t vel_abs(input vel_t v);
        vel_t r;
        if (v[VW-1]) begin
            r = -v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic vel_t vel_clamp(input vel_t v, input vel_t lim);
        vel_t r;
        if (v > lim) begin
            r = lim;
        end else if (v < -lim) begin
            r = -lim;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Vertical velocity picked by the paddle quarter that was struck.
    function automatic vel_t zone_vel(input logic [1:0] zone);
        vel_t r;
        case (zone)
            2'd0:    r = -4'sd2;
            2'd1:    r = -4'sd1;
            2'd2:    r = 4'sd1;
            2'd3:    r = 4'sd2;
            default: r = 4'sd0;
        endcase
        return r;
    endfunction

    // Spin contributed by a moving paddle.
    function automatic vel_t spin_vel(input logic [1:0] dir);
        vel_t r;
        case (dir)
            DIR_DOWN: r = 4'sd1;
            DIR_UP:   r = -4'sd1;
            default:  r = 4'sd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pong_ball_engine_if.sv
// Game-side bundle of the ball engine: move strobe, halt, paddle inputs and ball outputs.
// master = game logic driving the engine, slave = the engine itself.
interface pong_ball_engine_if #(
    parameter int XW = 11,
    parameter int YW = 10,
    parameter int SW = 8
);
    logic          tick;
    logic          halt;
    logic [YW-1:0] p1_pos;
    logic [YW-1:0] p2_pos;
    logic [SW-1:0] p1_size;
    logic [SW-1:0] p2_size;
    logic [1:0]    p1_dir;
    logic [1:0]    p2_dir;
    logic [XW-1:0] ball_x;
    logic [YW-1:0] ball_y;
    logic          scored_p1;
    logic          scored_p2;
    logic          hit;
    logic [2:0]    speed;
    logic [1:0]    state;

    modport master (
        output tick, halt, p1_pos, p2_pos, p1_size, p2_size, p1_dir, p2_dir,
        input  ball_x, ball_y, scored_p1, scored_p2, hit, speed, state
    );

    modport slave (
        input  tick, halt, p1_pos, p2_pos, p1_size, p2_size, p1_dir, p2_dir,
        output ball_x, ball_y, scored_p1, scored_p2, hit, speed, state
    );
endinterface

// File: rtl/pong_ball_engine_hit_zone.sv
// Paddle contact helper: vertical overlap of ball and paddle, and which quarter of
// the paddle the ball centre lines up with. Quarters come from shifts, no divider.
// A centre above the paddle top reads as quarter 0, below its bottom as quarter 3.
module pong_ball_engine_hit_zone #(
    parameter int YW        = 10,
    parameter int SW        = 8,
    parameter int BALL_SIZE = 30
) (
    input  logic [YW-1:0] ball_y_i,
    input  logic [YW-1:0] pad_pos_i,
    input  logic [SW-1:0] pad_size_i,
    output logic          overlap_o,
    output logic [1:0]    zone_o
);
    localparam int CW = ((YW > SW) ? YW : SW) + 3;
    localparam logic signed [CW-1:0] BALL_C = CW'(BALL_SIZE);
    localparam logic signed [CW-1:0] HALF_C = CW'(BALL_SIZE / 2);

    logic signed [CW-1:0] y_s;
    logic signed [CW-1:0] pos_s;
    logic signed [CW-1:0] size_s;
    logic signed [CW-1:0] c_s;
    logic signed [CW-1:0] q1_s;
    logic signed [CW-1:0] q2_s;
    logic signed [CW-1:0] q3_s;

    // Overlap test and quarter classification of the ball centre.
    always_comb begin
        y_s    = $signed({{(CW-YW){1'b0}}, ball_y_i});
        pos_s  = $signed({{(CW-YW){1'b0}}, pad_pos_i});
        size_s = $signed({{(CW-SW){1'b0}}, pad_size_i});
        q1_s   = $signed({{(CW-SW){1'b0}}, pad_size_i >> 3'd2});
        q2_s   = $signed({{(CW-SW){1'b0}}, pad_size_i >> 3'd1});
        q3_s   = q1_s + q2_s;
        c_s    = y_s + HALF_C - pos_s;

        if ((pad_size_i != '0) && (y_s + BALL_C >= pos_s) && (y_s < pos_s + size_s)) begin
            overlap_o = 1'b1;
        end else begin
            overlap_o = 1'b0;
        end

        if (c_s < q1_s) begin
            zone_o = 2'd0;
        end else if (c_s < q2_s) begin
            zone_o = 2'd1;
        end else if (c_s < q3_s) begin
            zone_o = 2'd2;
        end else begin
            zone_o = 2'd3;
        end
    end

endmodule

// File: rtl/pong_ball_engine.sv
// Ball engine: variable speed, paddle hit-zone deflection, serve/score FSM with a
// serve delay and a halt freeze. Advances once per tick strobe.
// Optional build macro PONG_SPIN_EN: a moving paddle adds +/-1 spin to vy on a hit.
module pong_ball_engine
    import pong_ball_engine_pkg::*;
#(
    parameter int FIELD_W     = FIELD_W_DEF,
    parameter int FIELD_H     = FIELD_H_DEF,
    parameter int BALL_SIZE   = BALL_SIZE_DEF,
    parameter int PAD_L_X     = PAD_L_X_DEF,
    parameter int PAD_R_X     = PAD_R_X_DEF,
    parameter int MAX_SPEED   = MAX_SPEED_DEF,
    parameter int SERVE_DELAY = SERVE_DELAY_DEF,
    parameter int XW          = XW_DEF,
    parameter int YW          = YW_DEF,
    parameter int SW          = SW_DEF
) (
    input logic               clk,
    input logic               b_rst,
    pong_ball_engine_if.slave eng_if
);
    localparam int XC   = XW + 2;
    localparam int YC   = YW + 2;
    localparam int CNTW = $clog2(SERVE_DELAY + 1);

    localparam logic signed [XC-1:0] BALL_X = XC'(BALL_SIZE);
    localparam logic signed [XC-1:0] PAD_L  = XC'(PAD_L_X);
    localparam logic signed [XC-1:0] PAD_R  = XC'(PAD_R_X);
    localparam logic signed [XC-1:0] FW     = XC'(FIELD_W);
    localparam logic signed [XC-1:0] ZERO_X = XC'(0);
    localparam logic signed [YC-1:0] BALL_Y = YC'(BALL_SIZE);
    localparam logic signed [YC-1:0] FH     = YC'(FIELD_H);
    localparam logic signed [YC-1:0] ZERO_Y = YC'(0);

    localparam logic [XW-1:0]   CENTRE_X  = XW'((FIELD_W - BALL_SIZE) / 2);
    localparam logic [YW-1:0]   CENTRE_Y  = YW'((FIELD_H - BALL_SIZE) / 2);
    localparam logic [XW-1:0]   X_MAX     = XW'(FIELD_W - BALL_SIZE);
    localparam logic [YW-1:0]   Y_MAX     = YW'(FIELD_H - BALL_SIZE);
    localparam logic [XW-1:0]   PAD_L_POS = XW'(PAD_L_X);
    localparam logic [XW-1:0]   PAD_R_POS = XW'(PAD_R_X - BALL_SIZE);
    localparam vel_t            VMAX      = vel_t'(MAX_SPEED);
    localparam logic [CNTW-1:0] DELAY_INIT = CNTW'(SERVE_DELAY);

    state_e          state_q;
    logic [CNTW-1:0] cnt_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;
    vel_t            vx_q;
    vel_t            vy_q;
    logic [2:0]      speed_q;
    logic            serve_left_q;
    logic            hit_q;
    logic            scored_p1_q;
    logic            scored_p2_q;

    logic signed [XC-1:0] x_s;
    logic signed [XC-1:0] nx_s;
    logic signed [YC-1:0] y_s;
    logic signed [YC-1:0] ny_s;
    logic                 ovl1_s;
    logic                 ovl2_s;
    logic [1:0]           zone1_s;
    logic [1:0]           zone2_s;
    vel_t                 spin1_s;
    vel_t                 spin2_s;
    vel_t                 vx_up_s;
    vel_t                 vy_pad_s;
    logic                 hit_l_s;
    logic                 hit_r_s;
    logic                 miss_l_s;
    logic                 miss_r_s;
    logic [XW-1:0]        x_d;
    logic [YW-1:0]        y_d;
    vel_t                 vx_d;
    vel_t                 vy_d;

    pong_ball_engine_hit_zone #(.YW(YW), .SW(SW), .BALL_SIZE(BALL_SIZE)) u_zone_p1 (
        .ball_y_i   (y_q),
        .pad_pos_i  (eng_if.p1_pos),
        .pad_size_i (eng_if.p1_size),
        .overlap_o  (ovl1_s),
        .zone_o     (zone1_s)
    );

    pong_ball_engine_hit_zone #(.YW(YW), .SW(SW), .BALL_SIZE(BALL_SIZE)) u_zone_p2 (
        .ball_y_i   (y_q),
        .pad_pos_i  (eng_if.p2_pos),
        .pad_size_i (eng_if.p2_size),
        .overlap_o  (ovl2_s),
        .zone_o     (zone2_s)
    );

`ifdef PONG_SPIN_EN
    assign spin1_s = spin_vel(eng_if.p1_dir);
    assign spin2_s = spin_vel(eng_if.p2_dir);
`else
    // Direction inputs stay on the interface but have no effect in this build.
    logic unused_dir_s;
    assign unused_dir_s = ^{eng_if.p1_dir, eng_if.p2_dir};
    assign spin1_s = 4'sd0;
    assign spin2_s = 4'sd0;
`endif

    // Next ball position and velocity for one MOVE tick: paddles, then misses, then walls.
    always_comb begin
        x_s      = $signed({2'b00, x_q});
        y_s      = $signed({2'b00, y_q});
        nx_s     = x_s + XC'(vx_q);
        ny_s     = y_s + YC'(vy_q);
        vx_up_s  = vel_clamp(vel_abs(vx_q) + 4'sd1, VMAX);

        hit_l_s  = vx_q[VW-1] && (x_s >= PAD_L) && (nx_s <= PAD_L) && ovl1_s;
        hit_r_s  = !vx_q[VW-1] && (vx_q != 4'sd0) && (x_s + BALL_X <= PAD_R)
                   && (nx_s + BALL_X >= PAD_R) && ovl2_s;
        miss_l_s = !hit_l_s && !hit_r_s && (nx_s <= ZERO_X);
        miss_r_s = !hit_l_s && !hit_r_s && !miss_l_s && (nx_s + BALL_X >= FW);

        vx_d     = vx_q;
        vy_pad_s = vy_q;
        if (hit_l_s) begin
            x_d      = PAD_L_POS;
            vx_d     = vx_up_s;
            vy_pad_s = vel_clamp(zone_vel(zone1_s) + spin1_s, VMAX);
        end else if (hit_r_s) begin
            x_d      = PAD_R_POS;
            vx_d     = -vx_up_s;
            vy_pad_s = vel_clamp(zone_vel(zone2_s) + spin2_s, VMAX);
        end else if (miss_l_s) begin
            x_d = '0;
        end else if (miss_r_s) begin
            x_d = X_MAX;
        end else begin
            x_d = nx_s[XW-1:0];
        end

        // Walls reflect whatever vy the paddle stage produced, so both apply together.
        if (ny_s <= ZERO_Y) begin
            y_d  = '0;
            vy_d = vel_abs(vy_pad_s);
        end else if (ny_s + BALL_Y >= FH) begin
            y_d  = Y_MAX;
            vy_d = -vel_abs(vy_pad_s);
        end else begin
            y_d  = ny_s[YW-1:0];
            vy_d = vy_pad_s;
        end
    end

    // Serve/score FSM with all ball registers and one-clk pulses.
    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            state_q      <= S_SCORED;
            cnt_q        <= DELAY_INIT;
            x_q          <= CENTRE_X;
            y_q          <= CENTRE_Y;
            vx_q         <= 4'sd1;
            vy_q         <= 4'sd1;
            speed_q      <= 3'd1;
            serve_left_q <= 1'b0;
            hit_q        <= 1'b0;
            scored_p1_q  <= 1'b0;
            scored_p2_q  <= 1'b0;
        end else begin
            hit_q       <= 1'b0;
            scored_p1_q <= 1'b0;
            scored_p2_q <= 1'b0;
            if (eng_if.halt) begin
                state_q <= S_HALT;
            end else if (state_q == S_HALT) begin
                state_q <= S_SCORED;
                cnt_q   <= DELAY_INIT;
            end else if (eng_if.tick) begin
                case (state_q)
                    S_SCORED: begin
                        if (cnt_q == '0) begin
                            state_q <= S_SERVE;
                            x_q     <= CENTRE_X;
                            y_q     <= CENTRE_Y;
                            vx_q    <= serve_left_q ? -4'sd1 : 4'sd1;
                            vy_q    <= 4'sd1;
                            speed_q <= 3'd1;
                        end else begin
                            cnt_q <= cnt_q - CNTW'(1);
                        end
                    end
                    S_SERVE: begin
                        state_q <= S_MOVE;
                    end
                    S_MOVE: begin
                        x_q     <= x_d;
                        y_q     <= y_d;
                        vx_q    <= vx_d;
                        vy_q    <= vy_d;
                        speed_q <= 3'(vel_abs(vx_d));
                        hit_q   <= hit_l_s | hit_r_s;
                        if (miss_l_s) begin
                            state_q      <= S_SCORED;
                            cnt_q        <= DELAY_INIT;
                            serve_left_q <= 1'b1;
                            scored_p2_q  <= 1'b1;
                        end else if (miss_r_s) begin
                            state_q      <= S_SCORED;
                            cnt_q        <= DELAY_INIT;
                            serve_left_q <= 1'b0;
                            scored_p1_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_SCORED;
                        cnt_q   <= DELAY_INIT;
                    end
                endcase
            end
        end
    end

    assign eng_if.ball_x    = x_q;
    assign eng_if.ball_y    = y_q;
    assign eng_if.scored_p1 = scored_p1_q;
    assign eng_if.scored_p2 = scored_p2_q;
    assign eng_if.hit       = hit_q;
    assign eng_if.speed     = speed_q;
    assign eng_if.state     = state_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Scoreboard bench for pong_ball_engine: a behavioural game model predicts every
// clock's outputs, pushes them to a queue, and each DUT cycle pops and compares.
module tb_pong_ball_engine;

    typedef struct {
        int x;
        int y;
        int spd;
        int st;
        int hit;
        int s1;
        int s2;
    } exp_t;

    logic clk   = 1'b0;
    logic b_rst = 1'b0;

    // Free-running system clock.
    always #5 clk = ~clk;

    pong_ball_engine_if #(.XW(11), .YW(10), .SW(8)) eng_if ();

    pong_ball_engine dut (
        .clk    (clk),
        .b_rst  (b_rst),
        .eng_if (eng_if)
    );

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model state (plain integers, spec encodings).
    int m_st, m_cnt, m_x, m_y, m_vx, m_vy;
    bit m_left;

    // Paddle stimulus values and selection mode (0 both present, 1 left absent, 2 right absent).
    int p1p, p2p, p1s, p2s, p1d, p2d;
    int pad_mode = 0;
    bit seen_s1  = 1'b0;
    bit seen_s2  = 1'b0;
    int max_spd  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input int exp);
        n_cmp++;
        if (obs !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int clamp_pos(input int v);
        if (v < 0) return 0;
        if (v > 1023) return 1023;
        return v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int deflect(input int y, input int p, input int s, input int d);
        int c, v, unused_d;
        unused_d = d;
        c = y + 15 - p;
        if (c < s / 4) v = -2;
        else if (c < s / 2) v = -1;
        else if (c < s / 2 + s / 4) v = 1;
        else v = 2;
`ifdef PONG_SPIN_EN
        if (d == 1) v = v + 1;
        else if (d == 2) v = v - 1;
`endif
        if (v > 4) v = 4;
        if (v < -4) v = -4;
        return v;
    endfunction

    function automatic int speed_up(input int vx);
        int a;
        a = iabs(vx) + 1;
        return (a > 4) ? 4 : a;
    endfunction

    task automatic model_reset();
        m_st = 1; m_cnt = 60; m_x = 497; m_y = 285; m_vx = 1; m_vy = 1; m_left = 1'b0;
    endtask

    task automatic push_exp(input int hit, input int s1, input int s2);
        exp_t e;
        e.x = m_x; e.y = m_y; e.spd = iabs(m_vx); e.st = m_st;
        e.hit = hit; e.s1 = s1; e.s2 = s2;
        sb_q.push_back(e);
    endtask

    task automatic model_step(input bit tk, input bit hl);
        int nx, ny, nvx, nvy, h, s1, s2;
        h = 0; s1 = 0; s2 = 0;
        if (hl) begin
            m_st = 3;
        end else if (m_st == 3) begin
            m_st = 1; m_cnt = 60;
        end else if (tk) begin
            if (m_st == 1) begin
                if (m_cnt == 0) begin
                    m_st = 2; m_x = 497; m_y = 285; m_vx = m_left ? -1 : 1; m_vy = 1;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end else if (m_st == 2) begin
                m_st = 0;
            end else begin
                nx = m_x + m_vx; ny = m_y + m_vy; nvx = m_vx; nvy = m_vy;
                if (m_vx < 0 && m_x >= 62 && nx <= 62 && p1s != 0 &&
                    m_y + 30 >= p1p && m_y < p1p + p1s) begin
                    m_x = 62; nvx = speed_up(m_vx); nvy = deflect(m_y, p1p, p1s, p1d); h = 1;
                end else if (m_vx > 0 && m_x + 30 <= 962 && nx + 30 >= 962 && p2s != 0 &&
                             m_y + 30 >= p2p && m_y < p2p + p2s) begin
                    m_x = 932; nvx = -speed_up(m_vx); nvy = deflect(m_y, p2p, p2s, p2d); h = 1;
                end else if (nx <= 0) begin
                    m_x = 0; s2 = 1; m_st = 1; m_cnt = 60; m_left = 1'b1;
                end else if (nx + 30 >= 1024) begin
                    m_x = 994; s1 = 1; m_st = 1; m_cnt = 60; m_left = 1'b0;
                end else begin
                    m_x = nx;
                end
                if (ny <= 0) begin
                    m_y = 0; nvy = iabs(nvy);
                end else if (ny + 30 >= 600) begin
                    m_y = 570; nvy = -iabs(nvy);
                end else begin
                    m_y = ny;
                end
                m_vx = nvx; m_vy = nvy;
            end
        end
        push_exp(h, s1, s2);
    endtask

    // Paddles placed around the model ball so every zone, size and edge case occurs.
    task automatic set_paddles();
        int c;
        p1s = $urandom_range(4, 255);
        c = $urandom_range(0, p1s + 29);
        p1p = clamp_pos(m_y + 15 - (c - 15));
        p2s = $urandom_range(4, 255);
        c = $urandom_range(0, p2s + 29);
        p2p = clamp_pos(m_y + 15 - (c - 15));
        if (pad_mode == 1) p1s = 0;
        if (pad_mode == 2) p2s = 0;
        p1d = $urandom_range(0, 3);
        p2d = $urandom_range(0, 3);
    endtask

    task automatic step(input bit tk, input bit hl);
        exp_t e;
        set_paddles();
        eng_if.tick    = tk;
        eng_if.halt    = hl;
        eng_if.p1_pos  = 10'(p1p);
        eng_if.p2_pos  = 10'(p2p);
        eng_if.p1_size = 8'(p1s);
        eng_if.p2_size = 8'(p2s);
        eng_if.p1_dir  = 2'(p1d);
        eng_if.p2_dir  = 2'(p2d);
        model_step(tk, hl);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("ball_x", 32'(eng_if.ball_x), e.x);
        check_eq("ball_y", 32'(eng_if.ball_y), e.y);
        check_eq("speed", 32'(eng_if.speed), e.spd);
        check_eq("state", 32'(eng_if.state), e.st);
        check_eq("hit", 32'(eng_if.hit), e.hit);
        check_eq("scored_p1", 32'(eng_if.scored_p1), e.s1);
        check_eq("scored_p2", 32'(eng_if.scored_p2), e.s2);
        if (eng_if.scored_p1) seen_s1 = 1'b1;
        if (eng_if.scored_p2) seen_s2 = 1'b1;
        if (int'(eng_if.speed) > max_spd) max_spd = int'(eng_if.speed);
    endtask

    initial begin
        exp_t e;
        eng_if.tick = 1'b0; eng_if.halt = 1'b0;
        eng_if.p1_pos = 10'd0; eng_if.p2_pos = 10'd0;
        eng_if.p1_size = 8'd0; eng_if.p2_size = 8'd0;
        eng_if.p1_dir = 2'd0; eng_if.p2_dir = 2'd0;
        model_reset();
        #23;
        b_rst = 1'b1;

        // Reset values.
        push_exp(0, 0, 0);
        e = sb_q.pop_front();
        check_eq("rst_x", 32'(eng_if.ball_x), e.x);
        check_eq("rst_y", 32'(eng_if.ball_y), e.y);
        check_eq("rst_state", 32'(eng_if.state), e.st);
        check_eq("rst_speed", 32'(eng_if.speed), e.spd);
        check_eq("rst_pulses", 32'({eng_if.hit, eng_if.scored_p1, eng_if.scored_p2}), 0);

        // Serve delay: SCORED for 60 ticks, SERVE at tick 61, MOVE next at the centre.
        for (int i = 1; i <= 61; i++) begin
            step(1'b1, 1'b0);
            if (i == 60) check_eq("delay_scored", 32'(eng_if.state), 1);
        end
        check_eq("delay_serve", 32'(eng_if.state), 2);
        step(1'b1, 1'b0);
        check_eq("serve_move", 32'(eng_if.state), 0);
        check_eq("serve_x", 32'(eng_if.ball_x), 497);
        check_eq("serve_y", 32'(eng_if.ball_y), 285);

        // Long rally with both paddles, occasional idle clocks without tick.
        for (int i = 0; i < 4000; i++) step($urandom_range(0, 7) != 0, 1'b0);
        check_eq("speed_cap", 32'(max_spd), 4);

        // Halt mid-move, stay frozen, release into SCORED with a full count.
        step(1'b1, 1'b1);
        check_eq("halt_state", 32'(eng_if.state), 3);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        check_eq("unhalt_state", 32'(eng_if.state), 1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0);

        // Left paddle absent: ball reaches the left wall, serve then goes left.
        pad_mode = 1;
        for (int i = 0; i < 4000 && !seen_s2; i++) step(1'b1, 1'b0);
        check_eq("miss_left_seen", 32'(seen_s2), 1);
        check_eq("miss_left_state", 32'(eng_if.state), 1);
        check_eq("miss_left_x", 32'(eng_if.ball_x), 0);
        for (int i = 0; i < 63; i++) step(1'b1, 1'b0);
        check_eq("serve_left_x", 32'(eng_if.ball_x), 496);

        // Right paddle absent: ball reaches the right wall, serve then goes right.
        pad_mode = 2;
        for (int i = 0; i < 4000 && !seen_s1; i++) step(1'b1, 1'b0);
        check_eq("miss_right_seen", 32'(seen_s1), 1);
        check_eq("miss_right_x", 32'(eng_if.ball_x), 994);
        pad_mode = 0;
        for (int i = 0; i < 63; i++) step(1'b1, 1'b0);
        check_eq("serve_right_x", 32'(eng_if.ball_x), 498);

        // Halt during the serve delay, then more play.
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 3) != 0, (i % 500) >= 497);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
